// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Owns the program counter, issues reads to a
// synchronous-read instruction memory (data returns one cycle after the
// strobe) and fills the IF/ID pipeline register. Supports decode stalls,
// which lose nothing thanks to a one-entry skid buffer, and redirects
// (branch/jump), which flush everything in flight.
//
// Ports
//   clk             in   core clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   pc_init         in   start PC, sampled in the first cycle after reset
//   stall           in   decode busy: hold PC and IF/ID
//   redirect_valid  in   branch/jump taken this cycle (beats stall)
//   redirect_pc     in   redirect target
//   imem_rd_en      out  instruction memory read strobe
//   imem_addr       out  instruction memory byte address (word aligned)
//   imem_rdata      in   read data, valid one cycle after imem_rd_en
//   if_id_valid     out  IF/ID holds a live instruction
//   if_id_pc        out  PC of the IF/ID instruction
//   if_id_pc4       out  if_id_pc + 4
//   if_id_instr     out  instruction word
//   align_err       out  sticky: a redirect target was not word aligned
//   fetch_count     out  instructions loaded into IF/ID (wrapping)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    pc_init,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [AW-1:0]    redirect_pc,
  output logic             imem_rd_en,
  output logic [AW-1:0]    imem_addr,
  input  logic [DW-1:0]    imem_rdata,
  output logic             if_id_valid,
  output logic [AW-1:0]    if_id_pc,
  output logic [AW-1:0]    if_id_pc4,
  output logic [DW-1:0]    if_id_instr,
  output logic             align_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [AW-1:0] word_align(input logic [AW-1:0] addr);
    word_align = {addr[AW-1:2], 2'b00};
  endfunction

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            fetch_c;
  logic            redir_c;
  logic            stall_c;
  logic            run_c;

  // request stage: read issued, data arrives next cycle
  logic            req_pend_p0;
  logic [AW-1:0]   req_pc_p0;

  // skid stage: response caught while decode was stalled
  logic            skid_vld_p1;
  logic [AW-1:0]   skid_pc_p1;
  logic [DW-1:0]   skid_instr_p1;

  logic [AW-1:0]   load_pc;
  logic [DW-1:0]   load_instr;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fetch_c = 1'b0;
    redir_c = 1'b0;
    stall_c = 1'b0;
    run_c   = 1'b0;
    case (state_q)
      ST_INIT: begin
        pc_d    = word_align(pc_init);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          redir_c = 1'b1;
          pc_d    = word_align(redirect_pc);
        end else if (stall) begin
          stall_c = 1'b1;
        end else begin
          run_c   = 1'b1;
          fetch_c = 1'b1;
          pc_d    = pc_q + AW'(4);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign imem_rd_en = fetch_c;
  assign imem_addr  = pc_q;

  // the skid entry is always older than a pending response, so it drains first
  assign load_pc    = skid_vld_p1 ? skid_pc_p1    : req_pc_p0;
  assign load_instr = skid_vld_p1 ? skid_instr_p1 : imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      pc_q        <= '0;
      req_pend_p0 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_instr <= '0;
      align_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pend_p0 <= fetch_c;
      if (redir_c) begin
        skid_vld_p1 <= 1'b0;
        if_id_valid <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) align_err <= 1'b1;
      end else if (stall_c) begin
        if (req_pend_p0) skid_vld_p1 <= 1'b1;
      end else if (run_c) begin
        if (skid_vld_p1 || req_pend_p0) begin
          skid_vld_p1 <= 1'b0;
          if_id_valid <= 1'b1;
          if_id_pc    <= load_pc;
          if_id_pc4   <= load_pc + AW'(4);
          if_id_instr <= load_instr;
          fetch_count <= fetch_count + CNT_W'(1);
        end else begin
          if_id_valid <= 1'b0;
        end
      end
    end
  end

  // data-only registers, qualified by the valid flags above
  always_ff @(posedge clk) begin
    if (fetch_c) req_pc_p0 <= pc_q;
    if (stall_c && req_pend_p0) begin
      skid_pc_p1    <= req_pc_p0;
      skid_instr_p1 <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_init = 32'd656;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        align_err;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.AW(32), .DW(32), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_init        (pc_init),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_instr    (if_id_instr),
    .align_err      (align_err),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // synchronous-read memory: word at address A holds A + 0x1000_0000
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= imem_addr + 32'h1000_0000;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // advance one cycle, then apply inputs for the new cycle and let them settle
  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rpc;
    #1;
  endtask

  initial begin
    // ---- 1: reset, then straight-line fetch from 656 ----
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_rd_en", imem_rd_en, 0);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_pc", if_id_pc, 0);
    chk("rst_pc4", if_id_pc4, 0);
    chk("rst_instr", if_id_instr, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_align", align_err, 0);
    chk("rst_count", fetch_count, 0);
    rst_n = 1'b1;
    #1;
    chk("init_rd_en", imem_rd_en, 0);
    cyc(0, 0, 0);
    chk("t1_rd_en0", imem_rd_en, 1);
    chk("t1_addr0", imem_addr, 656);
    cyc(0, 0, 0);
    chk("t1_addr1", imem_addr, 660);
    chk("t1_valid_lat", if_id_valid, 0);

    // ---- 2: stall two cycles right after the 660 read ----
    cyc(1, 0, 0);
    chk("t2_rd_en_st", imem_rd_en, 0);
    chk("t2_valid", if_id_valid, 1);
    chk("t2_pc", if_id_pc, 656);
    chk("t2_instr", if_id_instr, 32'h1000_0290);
    chk("t2_pc4", if_id_pc4, 660);
    chk("t2_cnt1", fetch_count, 1);
    cyc(1, 0, 0);
    chk("t2_hold_pc", if_id_pc, 656);
    chk("t2_hold_cnt", fetch_count, 1);
    chk("t2_hold_rd", imem_rd_en, 0);
    cyc(0, 0, 0);
    chk("t2_rel_rd", imem_rd_en, 1);
    chk("t2_rel_addr", imem_addr, 664);
    cyc(0, 0, 0);
    chk("t2_skid_pc", if_id_pc, 660);
    chk("t2_skid_instr", if_id_instr, 32'h1000_0294);
    chk("t2_cnt2", fetch_count, 2);
    chk("t2_addr668", imem_addr, 668);
    cyc(0, 0, 0);
    chk("t2_next_pc", if_id_pc, 664);
    chk("t2_next_valid", if_id_valid, 1);
    chk("t2_cnt3", fetch_count, 3);

    // ---- 3: redirect to 700 while stalled ----
    cyc(1, 1, 32'd700);
    chk("t3_rd_en", imem_rd_en, 0);
    chk("t3_pc_pre", if_id_pc, 668);
    chk("t3_cnt_pre", fetch_count, 4);
    cyc(0, 0, 0);
    chk("t3_flush", if_id_valid, 0);
    chk("t3_cnt_keep", fetch_count, 4);
    chk("t3_addr", imem_addr, 700);
    chk("t3_rd_en2", imem_rd_en, 1);
    chk("t3_align0", align_err, 0);
    cyc(0, 0, 0);
    chk("t3_addr704", imem_addr, 704);
    chk("t3_bubble", if_id_valid, 0);
    cyc(0, 0, 0);
    chk("t3_tgt_pc", if_id_pc, 700);
    chk("t3_tgt_valid", if_id_valid, 1);
    chk("t3_cnt5", fetch_count, 5);

    // ---- 4: misaligned redirect target ----
    cyc(0, 1, 32'd702);
    chk("t4_cnt6", fetch_count, 6);
    cyc(0, 0, 0);
    chk("t4_align", align_err, 1);
    chk("t4_addr", imem_addr, 700);
    chk("t4_flush", if_id_valid, 0);
    chk("t4_cnt_keep", fetch_count, 6);
    cyc(0, 0, 0);
    chk("t4_sticky", align_err, 1);

    // ---- 5: wrap around the top of the address space ----
    pc_init = 32'hFFFF_FFF8;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_align", align_err, 0);
    chk("t5_rst_valid", if_id_valid, 0);
    cyc(0, 0, 0);
    rst_n = 1'b1;
    #1;
    cyc(0, 0, 0);
    chk("t5_addr0", imem_addr, 32'hFFFF_FFF8);
    cyc(0, 0, 0);
    chk("t5_addr1", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("t5_addr2", imem_addr, 0);
    chk("t5_pc0", if_id_pc, 32'hFFFF_FFF8);
    cyc(0, 0, 0);
    chk("t5_pc1", if_id_pc, 32'hFFFF_FFFC);
    chk("t5_pc4wrap", if_id_pc4, 0);
    chk("t5_instr", if_id_instr, 32'h0FFF_FFFC);
    chk("t5_cnt2", fetch_count, 2);

    // ---- 6: reset while stalled with the skid full ----
    cyc(1, 0, 0);
    chk("t6_pc", if_id_pc, 0);
    chk("t6_cnt3", fetch_count, 3);
    cyc(1, 0, 0);
    pc_init = 32'h0000_0100;
    stall = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", if_id_valid, 0);
    chk("t6_rst_cnt", fetch_count, 0);
    chk("t6_rst_pc", if_id_pc, 0);
    chk("t6_rst_instr", if_id_instr, 0);
    chk("t6_rst_rd", imem_rd_en, 0);
    cyc(0, 0, 0);
    rst_n = 1'b1;
    #1;
    cyc(0, 0, 0);
    chk("t6_restart_addr", imem_addr, 32'h100);
    chk("t6_restart_cnt", fetch_count, 0);
    cyc(0, 0, 0);
    chk("t6_no_stale", if_id_valid, 0);
    cyc(0, 0, 0);
    chk("t6_first_pc", if_id_pc, 32'h100);
    chk("t6_first_cnt", fetch_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
